// File: rtl/mem_playback.sv
// Step-driven playback of a recorded RAM: each debounced button press fetches
// one word from a synchronous RAM and presents it to a valid/ready consumer.
module mem_playback #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              button,
  input  logic              clear,
  input  logic [ADDR_W:0]   wr_count,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  input  logic              data_ready,
  output logic              mem_empty,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FETCH   = 2'd1,
    CAPTURE = 2'd2,
    PRESENT = 2'd3
  } state_t;

  localparam logic [ADDR_W:0] PTR_MAX = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] PTR_ONE = {{ADDR_W{1'b0}}, 1'b1};

  state_t              state_q, state_d;
  logic [ADDR_W:0]     rd_ptr_q, rd_ptr_d;
  logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                sync1_q, sync2_q, sync3_q;
  logic [1:0]          arm_cnt_q, arm_cnt_d;
  logic                armed_q, armed_d;
  logic                step;

  // Steps are only honoured once the synchronizer has seen a released button
  // after reset, so a button held through reset cannot fire a step.
  assign step       = armed_q & sync2_q & ~sync3_q;
  assign mem_empty  = (rd_ptr_q >= wr_count);
  assign rd_en      = (state_q == FETCH);
  assign rd_addr    = rd_addr_q;
  assign data_out   = data_q;
  assign data_valid = (state_q == PRESENT);
  assign busy       = (state_q != IDLE);

  always_comb begin
    state_d   = state_q;
    rd_ptr_d  = rd_ptr_q;
    rd_addr_d = rd_addr_q;
    data_d    = data_q;
    arm_cnt_d = (arm_cnt_q == 2'd2) ? arm_cnt_q : arm_cnt_q + 2'd1;
    armed_d   = armed_q | ((arm_cnt_q == 2'd2) & ~sync2_q);

    case (state_q)
      IDLE: begin
        if (step && !mem_empty && !clear) begin
          state_d   = FETCH;
          rd_addr_d = rd_ptr_q[ADDR_W-1:0];
        end
      end
      FETCH:   state_d = CAPTURE;
      CAPTURE: begin
        data_d  = rd_data;
        state_d = PRESENT;
      end
      PRESENT: begin
        if (data_ready) begin
          rd_ptr_d = (rd_ptr_q == PTR_MAX) ? rd_ptr_q : rd_ptr_q + PTR_ONE;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Replay request overrides everything, including a pending handshake.
    if (clear) begin
      state_d  = IDLE;
      rd_ptr_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      rd_ptr_q  <= '0;
      rd_addr_q <= '0;
      data_q    <= '0;
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      sync3_q   <= 1'b0;
      arm_cnt_q <= 2'd0;
      armed_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      rd_ptr_q  <= rd_ptr_d;
      rd_addr_q <= rd_addr_d;
      data_q    <= data_d;
      sync1_q   <= button;
      sync2_q   <= sync1_q;
      sync3_q   <= sync2_q;
      arm_cnt_q <= arm_cnt_d;
      armed_q   <= armed_d;
    end
  end

endmodule
